// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and the caches.
//   ihit     : cache returned imemload this cycle
//   imemload : instruction data
//   imemREN  : read request from the fetch stage
//   imemaddr : fetch address
// master = fetch stage side, slave = cache side.
interface fetch_unit_if #(
  parameter int WORD_W = 32
);
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;

  modport master (input ihit, input imemload, output imemREN, output imemaddr);
  modport slave  (output ihit, output imemload, input imemREN, input imemaddr);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the pipelined MIPS core. Owns the PC, issues
// instruction reads, and feeds the IF/ID latch, absorbing cache wait states,
// hazard stalls (one-entry hold buffer), downstream redirects and halt.
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   imem           : instruction-memory bus (master side)
//   stall          : hazard unit says IF/ID must not load
//   redirect_valid : taken branch/jump resolved downstream
//   redirect_pc    : redirect target (low two bits ignored)
//   halt           : halt decoded
//   instr_out      : instruction to IF/ID
//   pcp4_out       : PC+4 to IF/ID
//   fetch_valid    : IF/ID load enable
//   ifid_flush     : IF/ID squash
//   pc_out         : current PC
module fetch_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = {WORD_W{1'b0}}
) (
  input  logic                CLK,
  input  logic                RST,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [WORD_W-1:0]   redirect_pc,
  input  logic                halt,
  output logic [WORD_W-1:0]   instr_out,
  output logic [WORD_W-1:0]   pcp4_out,
  output logic                fetch_valid,
  output logic                ifid_flush,
  output logic [WORD_W-1:0]   pc_out
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    HOLD   = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [WORD_W-1:0] PC_STEP    = {{(WORD_W-3){1'b0}}, 3'b100};
  localparam logic [WORD_W-1:0] ALIGN_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

  state_t              state_r;
  state_t              state_next_s;
  logic [WORD_W-1:0]   pc_r;
  logic [WORD_W-1:0]   pc_next_s;
  logic [WORD_W-1:0]   hold_instr_r;
  logic [WORD_W-1:0]   hold_next_s;
  logic [WORD_W-1:0]   pcp4_s;
  logic [WORD_W-1:0]   redirect_aligned_s;
  logic                imem_ren_s;

  // Wraps modulo 2^WORD_W naturally.
  assign pcp4_s             = pc_r + PC_STEP;
  assign redirect_aligned_s = redirect_pc & ALIGN_MASK;

  assign imem.imemREN  = imem_ren_s;
  assign imem.imemaddr = pc_r;
  assign pcp4_out      = pcp4_s;
  assign pc_out        = pc_r;

  // State, PC and hold-buffer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= FETCH;
      pc_r         <= PC_INIT;
      hold_instr_r <= {WORD_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      hold_instr_r <= hold_next_s;
    end
  end

  // Next-state and output decode; priority redirect > halt > stall > ihit.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    hold_next_s  = hold_instr_r;
    imem_ren_s   = 1'b0;
    fetch_valid  = 1'b0;
    ifid_flush   = 1'b0;
    instr_out    = {WORD_W{1'b0}};

    case (state_r)
      FETCH: begin
        imem_ren_s = 1'b1;
        if (redirect_valid) begin
          // Same-cycle ihit is wrong-path and dropped.
          ifid_flush = 1'b1;
          pc_next_s  = redirect_aligned_s;
        end else if (halt) begin
          state_next_s = HALTED;
        end else if (imem.ihit && stall) begin
          hold_next_s  = imem.imemload;
          state_next_s = HOLD;
        end else if (imem.ihit) begin
          fetch_valid = 1'b1;
          instr_out   = imem.imemload;
          pc_next_s   = pcp4_s;
        end else begin
          // Waiting on the cache: address stays put.
          pc_next_s = pc_r;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          ifid_flush   = 1'b1;
          hold_next_s  = {WORD_W{1'b0}};
          pc_next_s    = redirect_aligned_s;
          state_next_s = FETCH;
        end else if (halt) begin
          state_next_s = HALTED;
        end else if (stall) begin
          state_next_s = HOLD;
        end else begin
          fetch_valid  = 1'b1;
          instr_out    = hold_instr_r;
          pc_next_s    = pcp4_s;
          state_next_s = FETCH;
        end
      end

      HALTED: begin
        if (redirect_valid) begin
          // The halt itself was fetched down a mispredicted path.
          ifid_flush   = 1'b1;
          pc_next_s    = redirect_aligned_s;
          state_next_s = FETCH;
        end else begin
          state_next_s = HALTED;
        end
      end

      default: begin
        // Unused encoding: recover to a clean fetch.
        state_next_s = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expected values.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_out;
  logic [31:0] pcp4_out;
  logic        fetch_valid;
  logic        ifid_flush;
  logic [31:0] pc_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  fetch_unit_if #(.WORD_W(32)) imem_bus ();

  fetch_unit #(
    .WORD_W  (32),
    .PC_INIT (32'h0000_0000)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem           (imem_bus.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_out      (instr_out),
    .pcp4_out       (pcp4_out),
    .fetch_valid    (fetch_valid),
    .ifid_flush     (ifid_flush),
    .pc_out         (pc_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RST               = 1'b0;
    stall             = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    halt              = 1'b0;
    imem_bus.ihit     = 1'b0;
    imem_bus.imemload = 32'h0;
  endtask

  // One cycle with a delivered fetch at the current pc.
  task automatic do_fetch(input logic [31:0] word);
    idle_inputs();
    imem_bus.ihit     = 1'b1;
    imem_bus.imemload = word;
    tick();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    idle_inputs();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    tick();
    tick();
    #1;
    check_val("rst_pc", pc_out, 32'h0);
    check_val("rst_ren", {31'b0, imem_bus.imemREN}, 32'h1);
    check_val("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check_val("rst_flush", {31'b0, ifid_flush}, 32'h0);

    // Streaming fetch.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      imem_bus.ihit     = 1'b1;
      imem_bus.imemload = 32'h2001_0001 + 32'(i) * 32'h0001_0001;
      #1;
      check_val("stream_fv", {31'b0, fetch_valid}, 32'h1);
      check_val("stream_instr", instr_out, 32'h2001_0001 + 32'(i) * 32'h0001_0001);
      check_val("stream_pcp4", pcp4_out, 32'd4 * 32'(i + 1));
      check_val("stream_pc", pc_out, 32'd4 * 32'(i));
      tick();
    end
    do_fetch(32'h0000_0000);  // pc 0xC -> 0x10

    // Cache wait states at pc 0x10.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      stall = (i == 1);  // stall without ihit must be harmless
      #1;
      check_val("wait_ren", {31'b0, imem_bus.imemREN}, 32'h1);
      check_val("wait_addr", imem_bus.imemaddr, 32'h10);
      check_val("wait_fv", {31'b0, fetch_valid}, 32'h0);
      tick();
    end
    idle_inputs();
    imem_bus.ihit = 1'b1;
    #1;
    check_val("wait_end_fv", {31'b0, fetch_valid}, 32'h1);
    check_val("wait_end_pcp4", pcp4_out, 32'h14);
    tick();
    do_fetch(32'h0);
    do_fetch(32'h0);
    do_fetch(32'h0);  // pc now 0x20

    // Stall into HOLD.
    idle_inputs();
    imem_bus.ihit     = 1'b1;
    imem_bus.imemload = 32'hAC22_0000;
    stall             = 1'b1;
    #1;
    check_val("hold_in_fv", {31'b0, fetch_valid}, 32'h0);
    check_val("hold_in_pc", pc_out, 32'h20);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      stall = 1'b1;
      imem_bus.imemload = 32'hDEAD_BEEF;
      #1;
      check_val("hold_ren", {31'b0, imem_bus.imemREN}, 32'h0);
      check_val("hold_fv", {31'b0, fetch_valid}, 32'h0);
      check_val("hold_pc", pc_out, 32'h20);
      tick();
    end
    idle_inputs();
    #1;
    check_val("hold_out_fv", {31'b0, fetch_valid}, 32'h1);
    check_val("hold_out_instr", instr_out, 32'hAC22_0000);
    check_val("hold_out_pcp4", pcp4_out, 32'h24);
    tick();
    check_val("hold_after_pc", pc_out, 32'h24);
    check_val("hold_after_ren", {31'b0, imem_bus.imemREN}, 32'h1);

    // Redirect in FETCH with a same-cycle ihit.
    idle_inputs();
    imem_bus.ihit  = 1'b1;
    imem_bus.imemload = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check_val("rdf_flush", {31'b0, ifid_flush}, 32'h1);
    check_val("rdf_fv", {31'b0, fetch_valid}, 32'h0);
    tick();
    check_val("rdf_pc", pc_out, 32'h100);

    // Redirect in HOLD.
    idle_inputs();
    imem_bus.ihit     = 1'b1;
    imem_bus.imemload = 32'h1234_5678;
    stall             = 1'b1;
    tick();
    idle_inputs();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check_val("rdh_flush", {31'b0, ifid_flush}, 32'h1);
    check_val("rdh_fv", {31'b0, fetch_valid}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check_val("rdh_pc", pc_out, 32'h100);
    check_val("rdh_ren", {31'b0, imem_bus.imemREN}, 32'h1);
    check_val("rdh_nobuf_fv", {31'b0, fetch_valid}, 32'h0);

    // Halt at 0x40 with an ihit that must be discarded.
    do_redirect(32'h40);
    idle_inputs();
    halt          = 1'b1;
    imem_bus.ihit = 1'b1;
    #1;
    check_val("halt_fv", {31'b0, fetch_valid}, 32'h0);
    check_val("halt_flush", {31'b0, ifid_flush}, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      imem_bus.ihit = 1'b1;
      stall         = (i == 5);
      #1;
      check_val("halted_ren", {31'b0, imem_bus.imemREN}, 32'h0);
      check_val("halted_fv", {31'b0, fetch_valid}, 32'h0);
      check_val("halted_pc", pc_out, 32'h40);
      tick();
    end
    idle_inputs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    check_val("unhalt_flush", {31'b0, ifid_flush}, 32'h1);
    tick();
    idle_inputs();
    #1;
    check_val("unhalt_pc", pc_out, 32'h80);
    check_val("unhalt_ren", {31'b0, imem_bus.imemREN}, 32'h1);

    // Reset out of HALTED.
    idle_inputs();
    halt = 1'b1;
    tick();
    idle_inputs();
    RST = 1'b1;
    tick();
    idle_inputs();
    #1;
    check_val("halt_rst_pc", pc_out, 32'h0);
    check_val("halt_rst_ren", {31'b0, imem_bus.imemREN}, 32'h1);

    // PC wrap.
    do_redirect(32'hFFFF_FFFC);
    idle_inputs();
    imem_bus.ihit     = 1'b1;
    imem_bus.imemload = 32'h0BAD_F00D;
    #1;
    check_val("wrap_pcp4", pcp4_out, 32'h0);
    check_val("wrap_fv", {31'b0, fetch_valid}, 32'h1);
    tick();
    check_val("wrap_pc", pc_out, 32'h0);

    // Halt and redirect together: redirect wins.
    idle_inputs();
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check_val("hr_flush", {31'b0, ifid_flush}, 32'h1);
    tick();
    idle_inputs();
    #1;
    check_val("hr_pc", pc_out, 32'h200);
    check_val("hr_ren", {31'b0, imem_bus.imemREN}, 32'h1);
    imem_bus.ihit = 1'b1;
    #1;
    check_val("hr_fetch_fv", {31'b0, fetch_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
